// File: rtl/his_peak_scan_if.sv
// Bundle of the scan request/result signals and the histogram read port.
// The scanner takes the slave modport; whoever drives Start and serves the histogram is the master.
interface his_peak_scan_if #(
  parameter int unsigned DATA_SIZE   = 4,
  parameter int unsigned LENGTH_SIZE = 6
);
  logic                             Start;
  logic [LENGTH_SIZE-1:0]           Thresh;
  logic                             HisMemRD;
  logic [DATA_SIZE-1:0]             HisMemRDAdd;
  logic [LENGTH_SIZE-1:0]           HisMemRDData;
  logic                             Busy;
  logic                             Done;
  logic [DATA_SIZE-1:0]             PeakBin;
  logic [LENGTH_SIZE-1:0]           PeakCnt;
  logic [LENGTH_SIZE+DATA_SIZE-1:0] TotalCnt;
  logic [DATA_SIZE:0]               AboveCnt;

  modport master (
    output Start,
    output Thresh,
    output HisMemRDData,
    input  HisMemRD,
    input  HisMemRDAdd,
    input  Busy,
    input  Done,
    input  PeakBin,
    input  PeakCnt,
    input  TotalCnt,
    input  AboveCnt
  );

  modport slave (
    input  Start,
    input  Thresh,
    input  HisMemRDData,
    output HisMemRD,
    output HisMemRDAdd,
    output Busy,
    output Done,
    output PeakBin,
    output PeakCnt,
    output TotalCnt,
    output AboveCnt
  );
endinterface

// File: rtl/his_peak_scan.sv
// Scans every histogram bin once and reports the peak bin, its count, the total of all
// counts and how many bins reach a threshold latched at Start.
module his_peak_scan #(
  parameter int unsigned DATA_SIZE   = 4,
  parameter int unsigned DATA_NUM    = 16,
  parameter int unsigned LENGTH_SIZE = 6,
  parameter int unsigned RD_LAT      = 2
) (
  input logic             clk,
  input logic             rst,
  his_peak_scan_if.slave  bus
);

  localparam int unsigned TotalW = LENGTH_SIZE + DATA_SIZE;
  localparam int unsigned AboveW = DATA_SIZE + 1;
  localparam logic [DATA_SIZE-1:0] LastAddr = DATA_SIZE'(DATA_NUM - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

  state_e                 stateQ, stateD;
  logic [DATA_SIZE-1:0]   addrQ, addrD;
  logic [LENGTH_SIZE-1:0] threshQ, threshD;
  logic [DATA_SIZE-1:0]   peakBinQ, peakBinD;
  logic [LENGTH_SIZE-1:0] peakCntQ, peakCntD;
  logic [TotalW-1:0]      totalQ, totalD;
  logic [AboveW-1:0]      aboveQ, aboveD;

  // Read-return pipeline: valid bit and bin address travel with each issued read.
  logic [RD_LAT-1:0]      pipeValidQ;
  logic [DATA_SIZE-1:0]   pipeAddrQ [RD_LAT];

  logic                   sampleValid;
  logic [DATA_SIZE-1:0]   sampleAddr;
  logic                   earlierValid;

  logic                   hisMemRd;
  logic [DATA_SIZE-1:0]   hisMemRdAdd;
  logic                   busy;
  logic                   done;

  assign sampleValid = pipeValidQ[RD_LAT-1];
  assign sampleAddr  = pipeAddrQ[RD_LAT-1];

  always_comb begin
    earlierValid = 1'b0;
    for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
      earlierValid = earlierValid | pipeValidQ[i];
    end
  end

  always_comb begin
    stateD      = stateQ;
    addrD       = addrQ;
    threshD     = threshQ;
    peakBinD    = peakBinQ;
    peakCntD    = peakCntQ;
    totalD      = totalQ;
    aboveD      = aboveQ;
    hisMemRd    = 1'b0;
    hisMemRdAdd = '0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (stateQ)
      StIdle: begin
        busy = 1'b0;
        if (bus.Start) begin
          stateD   = StIssue;
          threshD  = bus.Thresh;
          addrD    = '0;
          peakBinD = '0;
          peakCntD = '0;
          totalD   = '0;
          aboveD   = '0;
        end
      end
      StIssue: begin
        hisMemRd    = 1'b1;
        hisMemRdAdd = addrQ;
        addrD       = addrQ + DATA_SIZE'(1);
        if (addrQ == LastAddr) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        // Leave once the final read is being consumed and nothing is still behind it.
        if (sampleValid && !earlierValid) begin
          stateD = StFinish;
        end
      end
      StFinish: begin
        done   = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase

    if (sampleValid) begin
      totalD = totalQ + TotalW'(bus.HisMemRDData);
      if (bus.HisMemRDData >= threshQ) begin
        aboveD = aboveQ + AboveW'(1);
      end
      // Bin 0 always seeds the peak; afterwards only a strictly larger count wins.
      if ((sampleAddr == '0) || (bus.HisMemRDData > peakCntQ)) begin
        peakCntD = bus.HisMemRDData;
        peakBinD = sampleAddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= StIdle;
      addrQ    <= '0;
      threshQ  <= '0;
      peakBinQ <= '0;
      peakCntQ <= '0;
      totalQ   <= '0;
      aboveQ   <= '0;
    end else begin
      stateQ   <= stateD;
      addrQ    <= addrD;
      threshQ  <= threshD;
      peakBinQ <= peakBinD;
      peakCntQ <= peakCntD;
      totalQ   <= totalD;
      aboveQ   <= aboveD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipeValidQ <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pipeAddrQ[i] <= '0;
      end
    end else begin
      pipeValidQ[0] <= (stateQ == StIssue);
      pipeAddrQ[0]  <= addrQ;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipeValidQ[i] <= pipeValidQ[i-1];
        pipeAddrQ[i]  <= pipeAddrQ[i-1];
      end
    end
  end

  assign bus.HisMemRD    = hisMemRd;
  assign bus.HisMemRDAdd = hisMemRdAdd;
  assign bus.Busy        = busy;
  assign bus.Done        = done;
  assign bus.PeakBin     = peakBinQ;
  assign bus.PeakCnt     = peakCntQ;
  assign bus.TotalCnt    = totalQ;
  assign bus.AboveCnt    = aboveQ;

  doneSingleCycle: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  readOnlyWhenBusy: assert property (@(posedge clk) disable iff (rst) hisMemRd |-> busy);

endmodule

// File: tb/tb_his_peak_scan.sv
// Randomized and directed scans of his_peak_scan against a plain arithmetic model of the
// histogram summary, plus timing, read-sequence and reset-abort checks.
module tb_his_peak_scan;

  localparam int unsigned DS = 4;
  localparam int unsigned DN = 16;
  localparam int unsigned LS = 6;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  his_peak_scan_if #(.DATA_SIZE(DS), .LENGTH_SIZE(LS)) busIf ();

  his_peak_scan #(
    .DATA_SIZE  (DS),
    .DATA_NUM   (DN),
    .LENGTH_SIZE(LS),
    .RD_LAT     (RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  // Histogram memory with a two-cycle read latency; junk is returned when no read is due.
  logic [LS-1:0] hist [DN];
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [DS-1:0] a1 = '0, a2 = '0;
  logic [LS-1:0] junk = '0;

  always @(posedge clk) begin
    v1   <= busIf.HisMemRD;
    a1   <= busIf.HisMemRDAdd;
    v2   <= v1;
    a2   <= a1;
    junk <= LS'($urandom);
  end

  assign busIf.HisMemRDData = v2 ? hist[a2] : junk;

  int            nChecks = 0;
  int            nErrors = 0;
  int            doneCnt = 0;
  int            badAddr = 0;
  logic [DS-1:0] rdAddrQ [$];

  always @(negedge clk) begin
    if (busIf.Done) doneCnt <= doneCnt + 1;
    if (busIf.HisMemRD) rdAddrQ.push_back(busIf.HisMemRDAdd);
    else if (busIf.HisMemRDAdd != '0) badAddr <= badAddr + 1;
  end

  task automatic checkEq(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, "_rd"},    int'(busIf.HisMemRD),    0);
    checkEq({tag, "_add"},   int'(busIf.HisMemRDAdd), 0);
    checkEq({tag, "_busy"},  int'(busIf.Busy),        0);
    checkEq({tag, "_done"},  int'(busIf.Done),        0);
    checkEq({tag, "_pbin"},  int'(busIf.PeakBin),     0);
    checkEq({tag, "_pcnt"},  int'(busIf.PeakCnt),     0);
    checkEq({tag, "_total"}, int'(busIf.TotalCnt),    0);
    checkEq({tag, "_above"}, int'(busIf.AboveCnt),    0);
  endtask

  // One complete scan, checked against the model; repulse pokes Start mid-scan and at Done.
  task automatic runScan(input logic [LS-1:0] t, input bit repulse);
    int lat;
    int pk, pc, tot, ab;
    bit ordered;
    pk  = 0;
    pc  = int'(hist[0]);
    tot = 0;
    ab  = 0;
    for (int i = 0; i < int'(DN); i++) begin
      tot += int'(hist[i]);
      if (hist[i] >= t) ab++;
      if (int'(hist[i]) > pc) begin
        pc = int'(hist[i]);
        pk = i;
      end
    end

    @(negedge clk);
    busIf.Start  = 1'b1;
    busIf.Thresh = t;
    rdAddrQ.delete();
    @(negedge clk);
    busIf.Start  = 1'b0;
    busIf.Thresh = LS'($urandom);
    lat = 1;
    checkEq("busy_issue", int'(busIf.Busy), 1);
    while (!busIf.Done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (repulse && lat == 5) begin
        busIf.Start  = 1'b1;
        busIf.Thresh = LS'($urandom);
      end else begin
        busIf.Start = 1'b0;
      end
    end
    checkEq("latency",   lat, int'(1 + DN + RL));
    checkEq("busy_done", int'(busIf.Busy),     1);
    checkEq("peak_bin",  int'(busIf.PeakBin),  pk);
    checkEq("peak_cnt",  int'(busIf.PeakCnt),  pc);
    checkEq("total_cnt", int'(busIf.TotalCnt), tot);
    checkEq("above_cnt", int'(busIf.AboveCnt), ab);
    checkEq("rd_count",  rdAddrQ.size(),       int'(DN));
    ordered = 1'b1;
    for (int i = 0; i < rdAddrQ.size() && i < int'(DN); i++) begin
      if (int'(rdAddrQ[i]) != i) ordered = 1'b0;
    end
    checkEq("rd_order", int'(ordered), 1);

    if (repulse) busIf.Start = 1'b1;
    @(negedge clk);
    busIf.Start = 1'b0;
    checkEq("done_width", int'(busIf.Done),     0);
    checkEq("busy_after", int'(busIf.Busy),     0);
    checkEq("hold_total", int'(busIf.TotalCnt), tot);
    checkEq("hold_peak",  int'(busIf.PeakBin),  pk);
    checkEq("hold_above", int'(busIf.AboveCnt), ab);
  endtask

  task automatic fillRandom(input int mode);
    for (int i = 0; i < int'(DN); i++) begin
      case (mode)
        0:       hist[i] = LS'($urandom);
        1:       hist[i] = LS'($urandom_range(0, 3));
        default: hist[i] = ($urandom_range(0, 1) == 1) ? LS'(63) : LS'(0);
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mode;
    int d0;
    logic [LS-1:0] t;
    rst          = 1'b1;
    busIf.Start  = 1'b0;
    busIf.Thresh = '0;
    for (int i = 0; i < int'(DN); i++) hist[i] = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < int'(DN); i++) hist[i] = LS'(i);
    runScan(LS'(8), 1'b0);
    checkEq("ramp_pbin",  int'(busIf.PeakBin),  15);
    checkEq("ramp_pcnt",  int'(busIf.PeakCnt),  15);
    checkEq("ramp_total", int'(busIf.TotalCnt), 120);
    checkEq("ramp_above", int'(busIf.AboveCnt), 8);

    for (int i = 0; i < int'(DN); i++) hist[i] = '0;
    runScan(LS'(0), 1'b0);
    checkEq("zero_pbin",  int'(busIf.PeakBin),  0);
    checkEq("zero_pcnt",  int'(busIf.PeakCnt),  0);
    checkEq("zero_total", int'(busIf.TotalCnt), 0);
    checkEq("zero_above", int'(busIf.AboveCnt), 16);

    for (int i = 0; i < int'(DN); i++) hist[i] = LS'(1);
    hist[3] = LS'(40);
    hist[9] = LS'(40);
    runScan(LS'(41), 1'b0);
    checkEq("tie_pbin",  int'(busIf.PeakBin),  3);
    checkEq("tie_pcnt",  int'(busIf.PeakCnt),  40);
    checkEq("tie_total", int'(busIf.TotalCnt), 94);
    checkEq("tie_above", int'(busIf.AboveCnt), 0);

    for (int i = 0; i < int'(DN); i++) hist[i] = LS'(63);
    runScan(LS'(63), 1'b0);
    checkEq("full_pbin",  int'(busIf.PeakBin),  0);
    checkEq("full_total", int'(busIf.TotalCnt), 1008);
    checkEq("full_above", int'(busIf.AboveCnt), 16);

    fillRandom(0);
    runScan(LS'($urandom), 1'b1);

    for (int n = 0; n < 20; n++) begin
      mode = int'($urandom_range(0, 2));
      fillRandom(mode);
      t = (mode == 1) ? LS'($urandom_range(0, 4)) : LS'($urandom);
      runScan(t, n[0]);
    end

    // Abort a scan with reset at cycle 10 while Start is also asserted.
    for (int i = 0; i < int'(DN); i++) hist[i] = LS'($urandom_range(1, 63));
    @(negedge clk);
    busIf.Start  = 1'b1;
    busIf.Thresh = LS'($urandom);
    @(negedge clk);
    busIf.Start = 1'b0;
    repeat (9) @(negedge clk);
    rst         = 1'b1;
    busIf.Start = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    busIf.Start = 1'b0;
    checkAllZero("abort");
    d0 = doneCnt;
    repeat (30) @(negedge clk);
    checkEq("abort_no_done", doneCnt, d0);
    checkEq("abort_idle",    int'(busIf.Busy), 0);

    fillRandom(0);
    runScan(LS'($urandom), 1'b0);

    checkEq("idle_addr_zero", badAddr, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
